// File: rtl/data_mem_responder.sv
// Data-memory responder: captures a one-cycle load/store strobe, waits WAIT_CYCLES,
// then performs a byte/half/word access on a word RAM and pulses ready (with err).
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_wr;
    logic        lat_both;
    logic [31:0] lat_addr;
    logic [2:0]  lat_f3;
    logic [31:0] lat_wdata;

    logic        sel_wr;
    logic        sel_both;
    logic [31:0] sel_addr;
    logic [2:0]  sel_f3;
    logic        sel_err;
    logic        sel_load;
    logic [31:0] sel_word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic        enter_resp;

    assign dbg_state = state;

    // When RESP is entered straight from IDLE the request has not been latched yet,
    // so the response is computed from the live inputs in that case.
    always_comb begin
        sel_wr   = lat_wr;
        sel_both = lat_both;
        sel_addr = lat_addr;
        sel_f3   = lat_f3;
        if (state == S_IDLE) begin
            sel_wr   = req_write;
            sel_both = req_read & req_write;
            sel_addr = addr;
            sel_f3   = funct3;
        end

        case (sel_f3)
            3'b000:  sel_err = 1'b0;
            3'b001:  sel_err = sel_addr[0];
            3'b010:  sel_err = |sel_addr[1:0];
            3'b100:  sel_err = sel_wr;
            3'b101:  sel_err = sel_wr | sel_addr[0];
            default: sel_err = 1'b1;
        endcase
        if (sel_both) sel_err = 1'b1;
        sel_load = !sel_wr && !sel_both;

        sel_word = mem[sel_addr[ADDR_W+1:2]];
        byte_v   = sel_word[{sel_addr[1:0], 3'b000} +: 8];
        half_v   = sel_word[{sel_addr[1], 4'b0000} +: 16];
        case (sel_f3[1:0])
            2'b00:   load_val = {{24{byte_v[7] & ~sel_f3[2]}}, byte_v};
            2'b01:   load_val = {{16{half_v[15] & ~sel_f3[2]}}, half_v};
            default: load_val = sel_word;
        endcase

        enter_resp = 1'b0;
        if (state == S_IDLE && (req_read || req_write))
            enter_resp = sel_both || (WAIT_CYCLES == 0);
        else if (state == S_WAIT && cnt == 4'd0)
            enter_resp = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_wr    <= 1'b0;
            lat_both  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
            rdata     <= 32'd0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_read || req_write) begin
                        lat_wr    <= req_write;
                        lat_both  <= req_read & req_write;
                        lat_addr  <= addr;
                        lat_f3    <= funct3;
                        lat_wdata <= wdata;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                        cnt       <= 4'(WAIT_CYCLES - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                state <= S_RESP;
                ready <= 1'b1;
                err   <= sel_err;
                if (sel_load) rdata <= sel_err ? 32'd0 : load_val;
            end
        end
    end

    // Stores commit on the edge that leaves RESP; an async reset during RESP moves
    // state to IDLE first, so an aborted store never touches the RAM.
    always_ff @(posedge clk) begin
        if (state == S_RESP && lat_wr && !err) begin
            case (lat_f3[1:0])
                2'b00:   mem[lat_addr[ADDR_W+1:2]][{lat_addr[1:0], 3'b000} +: 8] <= lat_wdata[7:0];
                2'b01:   mem[lat_addr[ADDR_W+1:2]][{lat_addr[1], 4'b0000} +: 16] <= lat_wdata[15:0];
                default: mem[lat_addr[ADDR_W+1:2]] <= lat_wdata;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 0, 1, 15) checked
// against a word-array reference model with directed and randomized accesses.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_v [3];
    logic        wr_v [3];
    logic [31:0] addr_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        busy_v [3];
    logic        err_v [3];
    logic [1:0]  dbg_v [3];

    int tests = 0;
    int fails = 0;
    int exp_lat [3] = '{1, 2, 16};

    logic [31:0] mem_m [3][1024];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_read(rd_v[0]), .req_write(wr_v[0]), .addr(addr_i),
        .funct3(funct3_i), .wdata(wdata_i), .rdata(rdata_v[0]), .ready(ready_v[0]),
        .busy(busy_v[0]), .err(err_v[0]), .dbg_state(dbg_v[0]));
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .req_read(rd_v[1]), .req_write(wr_v[1]), .addr(addr_i),
        .funct3(funct3_i), .wdata(wdata_i), .rdata(rdata_v[1]), .ready(ready_v[1]),
        .busy(busy_v[1]), .err(err_v[1]), .dbg_state(dbg_v[1]));
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset(reset), .req_read(rd_v[2]), .req_write(wr_v[2]), .addr(addr_i),
        .funct3(funct3_i), .wdata(wdata_i), .rdata(rdata_v[2]), .ready(ready_v[2]),
        .busy(busy_v[2]), .err(err_v[2]), .dbg_state(dbg_v[2]));

    function automatic logic [31:0] model_load(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd1:    return 32'($signed(sh[15:0]));
            3'd4:    return {24'd0, sh[7:0]};
            3'd5:    return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] w, logic [2:0] f3, logic [1:0] off,
                                                logic [31:0] d);
        logic [31:0] mask;
        case (f3)
            3'd0:    mask = 32'h0000_00FF;
            3'd1:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << (8 * off);
        return (w & ~mask) | ((d << (8 * off)) & mask);
    endfunction

    function automatic void model_step(int s, logic rd, logic wr, logic [31:0] a, logic [2:0] f3,
                                       logic [31:0] wd, output logic [31:0] er, output logic ee);
        int idx;
        logic [1:0] off;
        logic bad;
        idx = int'((a >> 2) % 1024);
        off = a[1:0];
        if (rd && wr)
            bad = 1'b1;
        else if (rd)
            bad = (f3 == 3 || f3 == 6 || f3 == 7) || ((f3 == 1 || f3 == 5) && off[0]) ||
                  (f3 == 2 && off != 0);
        else
            bad = (f3 > 2) || (f3 == 1 && off[0]) || (f3 == 2 && off != 0);
        ee = bad;
        if (rd && !wr)
            last_rd[s] = bad ? 32'd0 : model_load(mem_m[s][idx], f3, off);
        else if (wr && !rd && !bad)
            mem_m[s][idx] = model_store(mem_m[s][idx], f3, off, wd);
        er = last_rd[s];
    endfunction

    // Driver: one strobe cycle, then wait (bounded) for ready; lat=0 means timeout.
    task automatic txn(input int s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       output logic [31:0] r, output logic e, output int lat,
                       output logic pulse_ok, output logic [31:0] er, output logic ee);
        @(negedge clk);
        addr_i = a; funct3_i = f3; wdata_i = wd; rd_v[s] = rd; wr_v[s] = wr;
        lat = 0; r = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            rd_v[s] = 1'b0; wr_v[s] = 1'b0;
            if (ready_v[s]) begin
                lat = i; r = rdata_v[s]; e = err_v[s];
                break;
            end
        end
        @(negedge clk);
        pulse_ok = !ready_v[s] && !err_v[s] && !busy_v[s];
        model_step(s, rd, wr, a, f3, wd, er, ee);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (rdata_v[s] !== 32'd0 || ready_v[s] !== 1'b0 || busy_v[s] !== 1'b0 ||
                err_v[s] !== 1'b0 || dbg_v[s] !== 2'd0) begin
                fails++;
                $display("FAIL reset inst%0d: rdata=%h ready=%b busy=%b err=%b state=%0d, want all 0",
                         s, rdata_v[s], ready_v[s], busy_v[s], err_v[s], dbg_v[s]);
            end
        end
        reset = 1'b0;
        for (int s = 0; s < 3; s++) last_rd[s] = '0;
    endtask

    task automatic test_init();
        logic [31:0] r, er, v;
        logic e, ee, p;
        int lat;
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 24; w++) begin
                v = $urandom;
                txn(s, 1'b0, 1'b1, 32'(w * 4), 3'd2, v, r, e, lat, p, er, ee);
                tests++;
                if (lat != exp_lat[s] || e !== 1'b0 || !p) begin
                    fails++;
                    $display("FAIL init inst%0d w%0d: lat=%0d err=%b pulse=%b, want lat=%0d err=0 pulse=1",
                             s, w, lat, e, p, exp_lat[s]);
                end
            end
    endtask

    task automatic test_store_load();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat;
        txn(1, 1'b0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, r, e, lat, p, er, ee);
        tests++;
        if (lat != 2 || e !== 1'b0) begin
            fails++; $display("FAIL sw_10: lat=%0d err=%b, want lat=2 err=0", lat, e);
        end
        txn(1, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (lat != 2 || e !== 1'b0 || r !== 32'hDEAD_BEEF || !p) begin
            fails++;
            $display("FAIL lw_10: lat=%0d err=%b rdata=%h pulse=%b, want 2 0 deadbeef 1", lat, e, r, p);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat;
        txn(1, 1'b0, 1'b1, 32'h10, 3'd2, 32'h0, r, e, lat, p, er, ee);
        txn(1, 1'b0, 1'b1, 32'h13, 3'd0, 32'h0000_0080, r, e, lat, p, er, ee);
        txn(1, 1'b1, 1'b0, 32'h13, 3'd0, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'hFFFF_FF80 || e !== 1'b0) begin
            fails++; $display("FAIL lb_13: rdata=%h err=%b, want ffffff80 0", r, e);
        end
        txn(1, 1'b1, 1'b0, 32'h13, 3'd4, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'h0000_0080 || e !== 1'b0) begin
            fails++; $display("FAIL lbu_13: rdata=%h err=%b, want 00000080 0", r, e);
        end
        txn(1, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'h8000_0000) begin
            fails++; $display("FAIL lw_10_after_sb: rdata=%h, want 80000000", r);
        end
    endtask

    task automatic test_halves();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat;
        txn(1, 1'b0, 1'b1, 32'h20, 3'd2, 32'h5555_7777, r, e, lat, p, er, ee);
        txn(1, 1'b0, 1'b1, 32'h22, 3'd1, 32'h1234_ABCD, r, e, lat, p, er, ee);
        txn(1, 1'b1, 1'b0, 32'h22, 3'd1, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'hFFFF_ABCD || e !== 1'b0) begin
            fails++; $display("FAIL lh_22: rdata=%h err=%b, want ffffabcd 0", r, e);
        end
        txn(1, 1'b1, 1'b0, 32'h22, 3'd5, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'h0000_ABCD) begin
            fails++; $display("FAIL lhu_22: rdata=%h, want 0000abcd", r);
        end
        txn(1, 1'b1, 1'b0, 32'h20, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'hABCD_7777) begin
            fails++; $display("FAIL lw_20_after_sh: rdata=%h, want abcd7777", r);
        end
    endtask

    task automatic test_errors();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat;
        txn(1, 1'b1, 1'b0, 32'h11, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (e !== 1'b1 || r !== 32'd0 || lat != 2) begin
            fails++; $display("FAIL err_lw_11: err=%b rdata=%h lat=%0d, want 1 0 2", e, r, lat);
        end
        txn(1, 1'b0, 1'b1, 32'h21, 3'd1, 32'hFFFF_FFFF, r, e, lat, p, er, ee);
        tests++;
        if (e !== 1'b1 || r !== 32'd0 || !p) begin
            fails++; $display("FAIL err_sh_21: err=%b rdata=%h pulse=%b, want 1 0 1", e, r, p);
        end
        txn(1, 1'b1, 1'b0, 32'h20, 3'd3, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (e !== 1'b1 || r !== 32'd0) begin
            fails++; $display("FAIL err_f3_011: err=%b rdata=%h, want 1 0", e, r);
        end
        txn(1, 1'b1, 1'b0, 32'h20, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (e !== 1'b0 || r !== 32'hABCD_7777) begin
            fails++; $display("FAIL lw_20_after_err: err=%b rdata=%h, want 0 abcd7777", e, r);
        end
    endtask

    task automatic test_latency();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat;
        for (int s = 0; s < 3; s++) begin
            txn(s, 1'b1, 1'b0, 32'h8, 3'd2, 32'h0, r, e, lat, p, er, ee);
            tests++;
            if (lat != exp_lat[s] || r !== er || e !== 1'b0 || !p) begin
                fails++;
                $display("FAIL latency inst%0d: lat=%0d rdata=%h err=%b pulse=%b, want %0d %h 0 1",
                         s, lat, r, e, p, exp_lat[s], er);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] got, er;
        logic ee;
        int n, first;
        n = 0; first = 0; got = '0;
        @(negedge clk);
        addr_i = 32'h8; funct3_i = 3'd2; rd_v[2] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            rd_v[2] = (i == 3);
            if (i == 3) addr_i = 32'h0C;
            if (ready_v[2]) begin
                n++;
                if (n == 1) begin first = i; got = rdata_v[2]; end
            end
        end
        model_step(2, 1'b1, 1'b0, 32'h8, 3'd2, 32'h0, er, ee);
        tests++;
        if (n != 1 || first != 16 || got !== er) begin
            fails++;
            $display("FAIL busy_ignore: pulses=%0d first=%0d rdata=%h, want 1 16 %h", n, first, got, er);
        end
    endtask

    task automatic test_both_strobes();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat;
        for (int s = 0; s < 3; s++) begin
            txn(s, 1'b1, 1'b1, 32'h4, 3'd2, 32'hCAFE_F00D, r, e, lat, p, er, ee);
            tests++;
            if (lat != 1 || e !== 1'b1 || r !== er) begin
                fails++;
                $display("FAIL both_strobes inst%0d: lat=%0d err=%b rdata=%h, want 1 1 %h", s, lat, e, r, er);
            end
        end
        txn(0, 1'b1, 1'b0, 32'h4, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== er || e !== 1'b0) begin
            fails++; $display("FAIL both_no_write: rdata=%h err=%b, want %h 0", r, e, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, wd;
        logic e, ee, p, rd, wr;
        logic [2:0] f3;
        int lat, s, op, want_lat;
        for (int k = 0; k < 120; k++) begin
            s  = (k % 8 == 7) ? 2 : int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 11));
            rd = (op == 0) || (op > 5);
            wr = (op <= 5);
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 23) * 4) | 32'($urandom_range(0, 3));
            wd = $urandom;
            txn(s, rd, wr, a, f3, wd, r, e, lat, p, er, ee);
            want_lat = (rd && wr) ? 1 : exp_lat[s];
            tests++;
            if (lat != want_lat || e !== ee || r !== er || !p) begin
                fails++;
                $display("FAIL random#%0d inst%0d rd=%b wr=%b a=%h f3=%0d: lat=%0d err=%b rdata=%h pulse=%b, want %0d %b %h 1",
                         k, s, rd, wr, a, f3, lat, e, r, p, want_lat, ee, er);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r, er;
        logic e, ee, p;
        int lat, n;
        txn(1, 1'b0, 1'b1, 32'h40, 3'd2, 32'h1111_1111, r, e, lat, p, er, ee);
        @(negedge clk);
        addr_i = 32'h40; funct3_i = 3'd2; wdata_i = 32'h2222_2222; wr_v[1] = 1'b1;
        @(negedge clk);
        wr_v[1] = 1'b0;
        tests++;
        if (busy_v[1] !== 1'b1 || dbg_v[1] !== 2'd1) begin
            fails++; $display("FAIL abort_in_wait: busy=%b state=%0d, want 1 1", busy_v[1], dbg_v[1]);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (ready_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || err_v[1] !== 1'b0 || rdata_v[1] !== 32'd0) begin
            fails++;
            $display("FAIL abort_outputs: ready=%b busy=%b err=%b rdata=%h, want all 0",
                     ready_v[1], busy_v[1], err_v[1], rdata_v[1]);
        end
        for (int s = 0; s < 3; s++) last_rd[s] = '0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_v[1]) n++;
        end
        tests++;
        if (n != 0) begin
            fails++; $display("FAIL abort_no_ready: pulses=%0d, want 0", n);
        end
        txn(1, 1'b1, 1'b0, 32'h40, 3'd2, 32'h0, r, e, lat, p, er, ee);
        tests++;
        if (r !== 32'h1111_1111 || e !== 1'b0) begin
            fails++; $display("FAIL abort_ram_kept: rdata=%h err=%b, want 11111111 0", r, e);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            rd_v[s] = 1'b0;
            wr_v[s] = 1'b0;
        end
        test_reset();
        test_init();
        test_store_load();
        test_byte_lanes();
        test_halves();
        test_errors();
        test_latency();
        test_busy_ignore();
        test_both_strobes();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
